vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640: visible pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in pixel clocks.
REQ-003 Parameter V_ACTIVE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines.
REQ-004 Parameter SETTLE_CYCLES, 16: cycles pll_locked must stay high before timing starts (range 1..65535).
REQ-005 Parameter SYNC_ACTIVE, 1'b0: level of hsync/vsync during the sync pulse.
REQ-006 clk  input  1: pixel clock, 25.175 MHz, the only clock; all logic on its rising edge.
REQ-007 rst  input  1: reset, synchronous, active-high.
REQ-008 pll_locked  input  1: PLL lock indication, already synchronous to clk.
REQ-009 hsync  output  1: horizontal sync.
REQ-010 vsync  output  1: vertical sync.
REQ-011 de  output  1: display enable, high in the visible region.
REQ-012 x  output  10: horizontal counter, 0..H_TOTAL-1.
REQ-013 y  output  10: vertical counter, 0..V_TOTAL-1.
REQ-014 line_start  output  1: one-cycle pulse when x==0.
REQ-015 frame_start  output  1: one-cycle pulse when x==0 and y==0.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525) SHALL be computed at elaboration.
REQ-017 FSM states SHALL be WAIT_LOCK, SETTLE and RUN.
REQ-018 WAIT_LOCK -> SETTLE when pll_locked=1, with the settle counter cleared.
REQ-019 SETTLE SHALL count pll_locked-high cycles; after SETTLE_CYCLES consecutive high cycles it enters RUN with x=0 and y=0.
REQ-020 In any state, pll_locked=0 SHALL force WAIT_LOCK on the next cycle, with counters cleared and outputs at their idle values.
REQ-021 In RUN, x SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0; y SHALL increment when x wraps and wrap from V_TOTAL-1 to 0.
REQ-022 hsync, vsync, de and the pulses SHALL be registered and aligned to the x/y value presented in the same cycle, so the decode adds zero cycles of skew.
REQ-023 hsync SHALL equal SYNC_ACTIVE iff H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (656..751).
REQ-024 vsync SHALL equal SYNC_ACTIVE iff V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (490..491), for the whole of each such line.
REQ-025 de SHALL be 1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-026 The first RUN cycle SHALL present x=0, y=0, de=1, line_start=1 and frame_start=1.
REQ-027 Idle values (outside RUN) SHALL be hsync=vsync=~SYNC_ACTIVE, de=0, x=0, y=0, line_start=0, frame_start=0.

Reset
REQ-028 rst=1 SHALL force WAIT_LOCK, clear all counters and drive the idle values on the next edge; rst has priority over pll_locked.
REQ-029 Reset asserted mid-frame SHALL abort the frame; the restart SHALL pass through SETTLE again.

Configuration
REQ-030 Macro VGA_TIMING_GEN_PREFETCH_EN adds outputs fetch_x[9:0], fetch_y[9:0] and fetch_valid that lead x/y/de by exactly one cycle, for synchronous-RAM pixel fetch.
REQ-031 fetch_valid SHALL be 1 iff the next cycle has de=1; fetch_x/fetch_y SHALL wrap consistently with REQ-021.
REQ-032 Entering RUN SHALL present fetch_x=0, fetch_y=0, fetch_valid=1 in the last SETTLE cycle.
REQ-033 Without VGA_TIMING_GEN_PREFETCH_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-034 Package vga_pkg SHALL hold the 640x480@60 timing constants, the FSM state enum type and the counter width constant (10).
REQ-035 One sub-module, vga_axis_counter, SHALL be instantiated twice, for horizontal and vertical; it provides a wrapping counter with enable, clear and terminal-count flag.

Verification
REQ-036 Reset, then pll_locked=1 held -> first de=1 and frame_start exactly SETTLE_CYCLES+1 cycles after lock rises (17 by default).
REQ-037 Run one line -> hsync low for cycles x=656..751 (96 cycles); de high for x=0..639; line period 800 cycles.
REQ-038 Run one full frame -> vsync low for y=490..491 (1600 cycles); frame_start period 420000 cycles; y wraps 524->0.
REQ-039 Drop pll_locked at x=300, y=100 -> next cycle in WAIT_LOCK with idle values; relock restarts at x=0, y=0 after the settle count.
REQ-040 Pulse pll_locked low for 1 cycle during SETTLE (cycle 10) -> settle count restarts; no early start.
REQ-041 With VGA_TIMING_GEN_PREFETCH_EN -> fetch_x equals the next cycle's x for the full frame, including 799->0 and y 524->0 wraps; fetch_valid equals the next cycle's de.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants, counter width and FSM state type
// for the VGA timing generator.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BACK_DEF   = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BACK_DEF   = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } vga_state_e;

    // Half-open window test lo <= v < hi used for the sync pulse decode.
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// Wrapping 0..MAX-1 counter with synchronous clear, enable and terminal-count
// flag; exposes its next value so the parent can register decodes with no skew.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned MAX = H_TOTAL_DEF
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] next_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;
    assign next_o  = count_d;
    assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: lock/settle FSM, x/y counters and registered sync/de
// decode. Define VGA_TIMING_GEN_PREFETCH_EN to add one-cycle-ahead fetch_x/y/valid.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT       = H_FRONT_DEF,
    parameter int unsigned H_SYNC        = H_SYNC_DEF,
    parameter int unsigned H_BACK        = H_BACK_DEF,
    parameter int unsigned V_ACTIVE      = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT       = V_FRONT_DEF,
    parameter int unsigned V_SYNC        = V_SYNC_DEF,
    parameter int unsigned V_BACK        = V_BACK_DEF,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter logic        SYNC_ACTIVE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_GEN_PREFETCH_EN
    ,
    output logic [CNT_W-1:0] fetch_x,
    output logic [CNT_W-1:0] fetch_y,
    output logic             fetch_valid
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [15:0]      SET_LST = 16'(SETTLE_CYCLES - 1);

    vga_state_e state_q, state_d;
    logic [15:0] settle_q, settle_d;

    logic             run_hold, enter_run, cnt_clr;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             h_tc, v_tc;

    logic hsync_q, vsync_q, de_q, line_start_q, frame_start_q;

    // Any loss of lock (or reset) drops straight back to WAIT_LOCK.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (rst || !pll_locked) begin
            state_d  = WAIT_LOCK;
            settle_d = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
                SETTLE: begin
                    if (settle_q == SET_LST) begin
                        state_d  = RUN;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 16'd1;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    assign run_hold  = (state_q == RUN) && (state_d == RUN);
    assign enter_run = (state_q == SETTLE) && (state_d == RUN);
    assign cnt_clr   = !run_hold;

    vga_axis_counter #(.MAX(H_TOTAL)) u_h_cnt (
        .clk_i   (clk),
        .clr_i   (cnt_clr),
        .en_i    (1'b1),
        .count_o (x_q),
        .next_o  (x_d),
        .tc_o    (h_tc)
    );

    vga_axis_counter #(.MAX(V_TOTAL)) u_v_cnt (
        .clk_i   (clk),
        .clr_i   (cnt_clr),
        .en_i    (h_tc),
        .count_o (y_q),
        .next_o  (y_d),
        .tc_o    (v_tc)
    );

    // Decode the next x/y so the registered flags line up with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= ((state_d == RUN) && in_window(x_d, HS_LO, HS_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q       <= ((state_d == RUN) && in_window(y_d, VS_LO, VS_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            de_q          <= (state_d == RUN) && (x_d < H_ACT) && (y_d < V_ACT);
            line_start_q  <= enter_run || (run_hold && h_tc);
            frame_start_q <= enter_run || (run_hold && h_tc && v_tc);
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_GEN_PREFETCH_EN
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] fx_d, fy_d, fx_q, fy_q;
    logic             fv_d, fv_q;

    // Predict the position one edge ahead assuming lock stays high.
    always_comb begin
        fx_d = '0;
        fy_d = '0;
        fv_d = 1'b0;
        if (state_d == RUN) begin
            fx_d = (x_d == H_LAST) ? '0 : x_d + CNT_W'(1);
            if (x_d == H_LAST) begin
                fy_d = (y_d == V_LAST) ? '0 : y_d + CNT_W'(1);
            end else begin
                fy_d = y_d;
            end
            fv_d = (fx_d < H_ACT) && (fy_d < V_ACT);
        end else if ((state_d == SETTLE) && (settle_d == SET_LST)) begin
            fv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fx_q <= '0;
            fy_q <= '0;
            fv_q <= 1'b0;
        end else begin
            fx_q <= fx_d;
            fy_q <= fy_d;
            fv_q <= fv_d;
        end
    end

    assign fetch_x     = fx_q;
    assign fetch_y     = fy_q;
    assign fetch_valid = fv_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced timing so whole frames
// fit in a short run; the reference derives x/y from elapsed locked cycles.
module tb_vga_timing_gen;

    localparam int unsigned HA = 40, HF = 4, HS = 8, HB = 6;
    localparam int unsigned VA = 20, VF = 2, VSY = 2, VB = 3;
    localparam int unsigned S  = 16;
    localparam logic        SA = 1'b0;
    localparam longint      HT = HA + HF + HS + HB;
    localparam longint      VT = VA + VF + VSY + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       hsync, vsync, de, line_start, frame_start;
    logic [9:0] x, y;
`ifdef VGA_TIMING_GEN_PREFETCH_EN
    logic [9:0] fetch_x, fetch_y;
    logic       fetch_valid;
`endif

    int     checks = 0;
    int     errors = 0;
    longint hi_run = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .SETTLE_CYCLES(S), .SYNC_ACTIVE(SA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_TIMING_GEN_PREFETCH_EN
        ,
        .fetch_x     (fetch_x),
        .fetch_y     (fetch_y),
        .fetch_valid (fetch_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs after hr consecutive lock-high, reset-free edges.
    task automatic model(input longint hr, output logic [9:0] ex, output logic [9:0] ey,
                         output logic ehs, output logic evs, output logic ede,
                         output logic els, output logic efs);
        logic   run;
        longint t;
        run = (hr >= longint'(S) + 1);
        t   = run ? hr - (longint'(S) + 1) : 0;
        ex  = run ? 10'(t % HT) : 10'd0;
        ey  = run ? 10'((t / HT) % VT) : 10'd0;
        ehs = (run && ex >= HA + HF && ex < HA + HF + HS) ? SA : ~SA;
        evs = (run && ey >= VA + VF && ey < VA + VF + VSY) ? SA : ~SA;
        ede = run && ex < HA && ey < VA;
        els = run && ex == 0;
        efs = run && ex == 0 && ey == 0;
    endtask

    task automatic compare_all();
        logic [9:0] ex, ey;
        logic ehs, evs, ede, els, efs;
        model(hi_run, ex, ey, ehs, evs, ede, els, efs);
        check("x", 32'(x), 32'(ex));
        check("y", 32'(y), 32'(ey));
        check("hsync", 32'(hsync), 32'(ehs));
        check("vsync", 32'(vsync), 32'(evs));
        check("de", 32'(de), 32'(ede));
        check("line_start", 32'(line_start), 32'(els));
        check("frame_start", 32'(frame_start), 32'(efs));
`ifdef VGA_TIMING_GEN_PREFETCH_EN
        model(hi_run + 1, ex, ey, ehs, evs, ede, els, efs);
        check("fetch_x", 32'(fetch_x), 32'(ex));
        check("fetch_y", 32'(fetch_y), 32'(ey));
        check("fetch_valid", 32'(fetch_valid), 32'(ede));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (rst || !pll_locked) hi_run = 0;
        else hi_run++;
        #1;
        compare_all();
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 200);
        check(tag, 32'(n), 32'(S + 1));
        check({tag, "_de"}, 32'(de), 32'd1);
    endtask

    initial begin
        int n, hs_lo, vs_lo, de_hi, lines;
        logic [9:0] prev_y;

        for (int i = 0; i < 4; i++) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        pll_locked = 1'b1;
        wait_start("lock_to_start");

        n = 0; hs_lo = 0; vs_lo = 0; de_hi = 0; lines = 0; prev_y = '0;
        do begin
            if (hsync == SA) hs_lo++;
            if (vsync == SA) vs_lo++;
            if (de) de_hi++;
            if (line_start) lines++;
            prev_y = y;
            step();
            n++;
        end while (!frame_start && n < 4 * HT * VT);
        check("frame_period", 32'(n), 32'(HT * VT));
        check("hsync_low", 32'(hs_lo), 32'(HS * VT));
        check("vsync_low", 32'(vs_lo), 32'(VSY * HT));
        check("de_high", 32'(de_hi), 32'(HA * VA));
        check("lines", 32'(lines), 32'(VT));
        check("y_wrap", 32'(prev_y), 32'(VT - 1));

        n = 0;
        while (!(x == 10'd30 && y == 10'd10) && n < 4 * HT * VT) begin
            step();
            n++;
        end
        check("reach_drop_point", 32'({y, x}), 32'({10'd10, 10'd30}));
        pll_locked = 1'b0;
        step();
        check("drop_de", 32'(de), 32'd0);
        pll_locked = 1'b1;
        wait_start("relock_start");

        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        for (int i = 0; i < 10; i++) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_start("settle_glitch_start");

        for (int i = 0; i < 300; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_start("reset_restart");

        for (int i = 0; i < 20000; i++) begin
            pll_locked = ($urandom_range(0, 2999) != 0);
            rst        = ($urandom_range(0, 4999) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
